mmu_ram_seq: RTL and testbench
==============================

Name: mmu_ram_seq

Overview:
Sequencer and arbiter for the external MMU page-table RAM (8-bit address, 8-bit data, separate active-low read and write strobes). It shares the RAM between two requesters: per-CPU-cycle translation lookups, and configuration reads and writes issued when the CPU accesses the MMU register window. It generates strobe timing from the fast clock. With the optional feature compiled in, it also fills the table with an identity map after reset.

Parameters:
ADDR_W, 8, MMU RAM address width; page-table depth is 2**ADDR_W
DATA_W, 8, MMU RAM data width
RD_CYCLES, 2, cycles MMU_nRD is held low per read (min 1)
WR_CYCLES, 1, cycles MMU_nWR is held low per write (min 1)

Ports:
CLKX4  in  1  sole clock; all logic is on the rising edge
RESET  in  1  synchronous, active-high reset
XLAT_REQ  in  1  translation lookup request; level, held until XLAT_ACK
XLAT_ADDR  in  ADDR_W  table index for lookup
XLAT_ACK  out  1  one-cycle pulse; XLAT_DATA is valid from this cycle onward
XLAT_DATA  out  DATA_W  registered lookup result; holds its value until the next lookup
CFG_REQ  in  1  configuration access request; level, held until CFG_ACK
CFG_RnW  in  1  1 = read, 0 = write
CFG_ADDR  in  ADDR_W  table index
CFG_WDATA  in  DATA_W  write data
CFG_ACK  out  1  one-cycle completion pulse
CFG_RDATA  out  DATA_W  registered read result
INIT_BUSY  out  1  high while the reset fill runs
MMU_ADDR  out  ADDR_W  RAM address, registered
MMU_nRD  out  1  RAM read strobe, registered
MMU_nWR  out  1  RAM write strobe, registered
MMU_DATA_OUT  out  DATA_W  RAM write data
MMU_DATA_OE  out  1  drive enable for the RAM data bus
MMU_DATA_IN  in  DATA_W  RAM read data

Behaviour:
- Reset values: MMU_nRD=1, MMU_nWR=1, MMU_DATA_OE=0, MMU_ADDR=0, MMU_DATA_OUT=0, XLAT_ACK=0, CFG_ACK=0, XLAT_DATA=0, CFG_RDATA=0.
- Reset state: INIT if MMU_SEQ_INIT_EN is defined, else IDLE. INIT_BUSY=1 out of reset when the feature is in, 0 otherwise.
- States: INIT_SETUP, INIT_STRB, INIT_HOLD, IDLE, RD, W_SETUP, W_STRB, W_HOLD, DONE.
- IDLE arbitration:
  - XLAT_REQ has priority over CFG_REQ.
  - A sticky `cfg_owed` bit sets when CFG_REQ is pending while an XLAT is granted.
  - When cfg_owed=1, a pending CFG wins the next IDLE grant even if XLAT_REQ is high. cfg_owed clears on CFG grant.
  - Consequence: a CFG request waits for at most one XLAT.
- Read (XLAT, or CFG with CFG_RnW=1):
  - Request is sampled in IDLE at cycle c0.
  - RD occupies c1..c(RD_CYCLES): MMU_ADDR = requested index, MMU_nRD=0.
  - MMU_DATA_IN is captured on the last RD edge.
  - DONE at c(RD_CYCLES+1): the matching ACK is 1, MMU_nRD=1.
  - Return to IDLE. Default latency from sample to ACK is 3 cycles.
- Write (CFG with CFG_RnW=0):
  - W_SETUP, 1 cycle: MMU_ADDR and MMU_DATA_OUT are loaded, OE=1, nWR=1.
  - W_STRB, WR_CYCLES cycles: nWR=0.
  - W_HOLD, 1 cycle: nWR=1, OE=1.
  - DONE: CFG_ACK=1, OE=0.
- Request sampling: requests are not sampled in DONE. A requester must drop REQ at the edge ending its ACK cycle. A REQ still high in the following IDLE is a new request.
- Bus turnaround: every access starts from IDLE, giving at least one idle cycle between accesses. OE is never 1 while nRD=0. nRD and nWR are never both 0.
- Inputs are captured at grant. Changes to XLAT_ADDR, CFG_* or MMU_DATA_IN outside their sample points have no effect.
- Reset mid-access: the access aborts. All strobes, OE and ACKs are at reset values after the edge, and no ACK is issued for the aborted request.

Optional Feature:
MMU_SEQ_INIT_EN
- Defined:
  - After reset, write entry i = i[DATA_W-1:0] for i = 0 .. 2**ADDR_W-1, using the INIT_SETUP/INIT_STRB/INIT_HOLD sequence with the same timing as a write.
  - There is no DONE state and no ACK between entries.
  - The counter moves to IDLE after the last index; no wrap and no second pass.
  - INIT_BUSY=1 throughout and drops to 0 in the first IDLE cycle. Default duration is 256×3 = 768 cycles.
  - XLAT_REQ and CFG_REQ are held pending (not lost) during INIT and are arbitrated normally in the first IDLE.
- Undefined: no INIT states, INIT_BUSY is tied to 0, and the block enters IDLE directly from reset.

Test Plan:
- Reset, then XLAT_REQ with XLAT_ADDR=0x12 and the RAM model returning 0x5A → MMU_nRD low for exactly 2 cycles at address 0x12; XLAT_ACK pulses 3 cycles after sampling; XLAT_DATA=0x5A.
- CFG write with CFG_ADDR=0x34, CFG_WDATA=0xA5 → sequence setup/strobe/hold with OE high for 3 cycles and nWR low for 1 cycle; the RAM model holds 0xA5 at 0x34; CFG_ACK pulses once; a CFG read of 0x34 then returns CFG_RDATA=0xA5.
- XLAT_REQ held continuously while CFG_REQ is asserted → grants XLAT, CFG, XLAT in that order; CFG_ACK arrives after at most one XLAT_ACK.
- MMU_SEQ_INIT_EN defined: after RESET, INIT_BUSY=1 for 768 cycles; RAM model entries 0x00..0xFF hold their own index. An XLAT_REQ raised at cycle 10 is acknowledged only after INIT_BUSY falls.
- RESET asserted during W_STRB → nWR=1 and OE=0 at the next edge, no CFG_ACK; in the non-init build the block is in IDLE the cycle after RESET drops.
- Checker over all tests: never OE=1 while nRD=0, never nRD=0 and nWR=0 together, and every ACK is exactly 1 cycle wide.

Source files
------------

// File: rtl/mmu_ram_seq.sv
// mmu_ram_seq: sequencer/arbiter for the external MMU page-table RAM.
// Two requesters share the RAM: translation lookups (XLAT_*) and
// configuration reads/writes (CFG_*). XLAT has priority, but a CFG that
// waited behind one XLAT wins the next grant. All RAM strobes, address,
// write data and output enable are registered and timed from CLKX4.
//
// Optional build macro: MMU_SEQ_INIT_EN -- when defined, the block fills
// the table with an identity map (entry i = i) after reset and holds
// INIT_BUSY high until the fill completes. When undefined, INIT_BUSY is 0
// and the block starts in IDLE.
//
// Ports:
//   CLKX4, RESET                 clock, synchronous active-high reset
//   XLAT_REQ/ADDR -> ACK/DATA    lookup request (level) and registered result
//   CFG_REQ/RnW/ADDR/WDATA       config request (level)
//   CFG_ACK/RDATA                config completion pulse and read result
//   INIT_BUSY                    identity fill in progress
//   MMU_ADDR/nRD/nWR             RAM address and active-low strobes
//   MMU_DATA_OUT/OE/IN           RAM write data, drive enable, read data
module mmu_ram_seq #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic              CLKX4,
  input  logic              RESET,
  input  logic              XLAT_REQ,
  input  logic [ADDR_W-1:0] XLAT_ADDR,
  output logic              XLAT_ACK,
  output logic [DATA_W-1:0] XLAT_DATA,
  input  logic              CFG_REQ,
  input  logic              CFG_RnW,
  input  logic [ADDR_W-1:0] CFG_ADDR,
  input  logic [DATA_W-1:0] CFG_WDATA,
  output logic              CFG_ACK,
  output logic [DATA_W-1:0] CFG_RDATA,
  output logic              INIT_BUSY,
  output logic [ADDR_W-1:0] MMU_ADDR,
  output logic              MMU_nRD,
  output logic              MMU_nWR,
  output logic [DATA_W-1:0] MMU_DATA_OUT,
  output logic              MMU_DATA_OE,
  input  logic [DATA_W-1:0] MMU_DATA_IN
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    ST_INIT_SETUP,
    ST_INIT_STRB,
    ST_INIT_HOLD,
    ST_IDLE,
    ST_RD,
    ST_W_SETUP,
    ST_W_STRB,
    ST_W_HOLD,
    ST_DONE
  } state_t;

`ifdef MMU_SEQ_INIT_EN
  localparam state_t RST_STATE = ST_INIT_SETUP;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              nrd_q, nrd_d;
  logic              nwr_q, nwr_d;
  logic              oe_q, oe_d;
  logic              xlat_ack_q, xlat_ack_d;
  logic              cfg_ack_q, cfg_ack_d;
  logic [DATA_W-1:0] xlat_data_q, xlat_data_d;
  logic [DATA_W-1:0] cfg_rdata_q, cfg_rdata_d;
  logic              owner_cfg_q, owner_cfg_d;
  logic              cfg_owed_q, cfg_owed_d;
  logic              xlat_win;
`ifdef MMU_SEQ_INIT_EN
  logic              init_busy_q, init_busy_d;
`endif

  // XLAT wins unless a CFG already waited behind an earlier XLAT grant
  assign xlat_win = XLAT_REQ && !(cfg_owed_q && CFG_REQ);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    nrd_d       = nrd_q;
    nwr_d       = nwr_q;
    oe_d        = oe_q;
    xlat_ack_d  = 1'b0;
    cfg_ack_d   = 1'b0;
    xlat_data_d = xlat_data_q;
    cfg_rdata_d = cfg_rdata_q;
    owner_cfg_d = owner_cfg_q;
    cfg_owed_d  = cfg_owed_q;
`ifdef MMU_SEQ_INIT_EN
    init_busy_d = init_busy_q;
`endif

    case (state_q)
`ifdef MMU_SEQ_INIT_EN
      // Address/data for the current entry are already on the bus here
      ST_INIT_SETUP: begin
        oe_d    = 1'b1;
        nwr_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_INIT_STRB;
      end
      ST_INIT_STRB: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          nwr_d   = 1'b1;
          state_d = ST_INIT_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Advance to the next entry, or finish after the last index
      ST_INIT_HOLD: begin
        if (&addr_q) begin
          oe_d        = 1'b0;
          init_busy_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = DATA_W'(addr_q + ADDR_W'(1));
          state_d = ST_INIT_SETUP;
        end
      end
`endif
      ST_IDLE: begin
        if (xlat_win) begin
          owner_cfg_d = 1'b0;
          addr_d      = XLAT_ADDR;
          nrd_d       = 1'b0;
          cnt_d       = '0;
          state_d     = ST_RD;
          if (CFG_REQ) cfg_owed_d = 1'b1;
        end else if (CFG_REQ) begin
          owner_cfg_d = 1'b1;
          cfg_owed_d  = 1'b0;
          addr_d      = CFG_ADDR;
          cnt_d       = '0;
          if (CFG_RnW) begin
            nrd_d   = 1'b0;
            state_d = ST_RD;
          end else begin
            wdata_d = CFG_WDATA;
            oe_d    = 1'b1;
            state_d = ST_W_SETUP;
          end
        end
      end
      // Read data is captured on the edge that ends the last strobe cycle
      ST_RD: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          nrd_d   = 1'b1;
          state_d = ST_DONE;
          if (owner_cfg_q) begin
            cfg_rdata_d = MMU_DATA_IN;
            cfg_ack_d   = 1'b1;
          end else begin
            xlat_data_d = MMU_DATA_IN;
            xlat_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_W_SETUP: begin
        nwr_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_W_STRB;
      end
      ST_W_STRB: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          nwr_d   = 1'b1;
          state_d = ST_W_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_W_HOLD: begin
        oe_d      = 1'b0;
        cfg_ack_d = 1'b1;
        state_d   = ST_DONE;
      end
      // Requests are not sampled here; the requester drops REQ meanwhile
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        nrd_d   = 1'b1;
        nwr_d   = 1'b1;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge CLKX4) begin
    if (RESET) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      oe_q        <= 1'b0;
      xlat_ack_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
      xlat_data_q <= '0;
      cfg_rdata_q <= '0;
      owner_cfg_q <= 1'b0;
      cfg_owed_q  <= 1'b0;
`ifdef MMU_SEQ_INIT_EN
      init_busy_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      nrd_q       <= nrd_d;
      nwr_q       <= nwr_d;
      oe_q        <= oe_d;
      xlat_ack_q  <= xlat_ack_d;
      cfg_ack_q   <= cfg_ack_d;
      xlat_data_q <= xlat_data_d;
      cfg_rdata_q <= cfg_rdata_d;
      owner_cfg_q <= owner_cfg_d;
      cfg_owed_q  <= cfg_owed_d;
`ifdef MMU_SEQ_INIT_EN
      init_busy_q <= init_busy_d;
`endif
    end
  end

`ifdef MMU_SEQ_INIT_EN
  assign INIT_BUSY = init_busy_q;
`else
  assign INIT_BUSY = 1'b0;
`endif

  assign XLAT_ACK     = xlat_ack_q;
  assign XLAT_DATA    = xlat_data_q;
  assign CFG_ACK      = cfg_ack_q;
  assign CFG_RDATA    = cfg_rdata_q;
  assign MMU_ADDR     = addr_q;
  assign MMU_nRD      = nrd_q;
  assign MMU_nWR      = nwr_q;
  assign MMU_DATA_OUT = wdata_q;
  assign MMU_DATA_OE  = oe_q;

endmodule

// File: tb/tb_mmu_ram_seq.sv
// Testbench for mmu_ram_seq: RAM model, scoreboard of expected ACKs
// (popped by a negedge monitor that also checks bus invariants) and
// directed stimulus with hand-computed timing.
module tb_mmu_ram_seq;

  logic       CLKX4 = 1'b0;
  logic       RESET;
  logic       XLAT_REQ;
  logic [7:0] XLAT_ADDR;
  logic       XLAT_ACK;
  logic [7:0] XLAT_DATA;
  logic       CFG_REQ;
  logic       CFG_RnW;
  logic [7:0] CFG_ADDR;
  logic [7:0] CFG_WDATA;
  logic       CFG_ACK;
  logic [7:0] CFG_RDATA;
  logic       INIT_BUSY;
  logic [7:0] MMU_ADDR;
  logic       MMU_nRD;
  logic       MMU_nWR;
  logic [7:0] MMU_DATA_OUT;
  logic       MMU_DATA_OE;
  logic [7:0] MMU_DATA_IN;

  always #5 CLKX4 = ~CLKX4;

  mmu_ram_seq dut (
    .CLKX4(CLKX4), .RESET(RESET),
    .XLAT_REQ(XLAT_REQ), .XLAT_ADDR(XLAT_ADDR), .XLAT_ACK(XLAT_ACK), .XLAT_DATA(XLAT_DATA),
    .CFG_REQ(CFG_REQ), .CFG_RnW(CFG_RnW), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
    .CFG_ACK(CFG_ACK), .CFG_RDATA(CFG_RDATA), .INIT_BUSY(INIT_BUSY),
    .MMU_ADDR(MMU_ADDR), .MMU_nRD(MMU_nRD), .MMU_nWR(MMU_nWR),
    .MMU_DATA_OUT(MMU_DATA_OUT), .MMU_DATA_OE(MMU_DATA_OE), .MMU_DATA_IN(MMU_DATA_IN)
  );

  // RAM model with a bench-side preload port
  logic [7:0] ram [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  always @(posedge CLKX4) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (!MMU_nWR) ram[MMU_ADDR] <= MMU_DATA_OUT;
  end

  // Junk value when not reading exposes captures outside the strobe window
  assign MMU_DATA_IN = MMU_nRD ? 8'hEE : ram[MMU_ADDR];

  typedef struct packed {
    logic       is_cfg;
    logic       chk_data;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_xack = 1'b0;
  logic prev_cack = 1'b0;

  function automatic exp_t mk(input logic is_cfg, input logic chk, input logic [7:0] d);
    exp_t e;
    e.is_cfg   = is_cfg;
    e.chk_data = chk;
    e.data     = d;
    return e;
  endfunction

  // Monitor: bus invariants, ACK width, and scoreboard pops
  always @(negedge CLKX4) begin
    exp_t e;
    checks++;
    if (MMU_DATA_OE && !MMU_nRD) begin
      failures++;
      $display("FAIL oe_during_rd at %0t: OE=%0b nRD=%0b", $time, MMU_DATA_OE, MMU_nRD);
    end
    checks++;
    if (!MMU_nRD && !MMU_nWR) begin
      failures++;
      $display("FAIL rd_wr_overlap at %0t: nRD=%0b nWR=%0b", $time, MMU_nRD, MMU_nWR);
    end
    if (XLAT_ACK) begin
      checks++;
      if (prev_xack) begin
        failures++;
        $display("FAIL xlat_ack_width at %0t: ack high for more than 1 cycle, required 1", $time);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xlat_unexpected_ack at %0t: data=%02h, required no ack", $time, XLAT_DATA);
      end else begin
        e = exp_q.pop_front();
        if (e.is_cfg || XLAT_DATA != e.data) begin
          failures++;
          $display("FAIL xlat_resp at %0t: got XLAT data=%02h, required is_cfg=%0b data=%02h",
                   $time, XLAT_DATA, e.is_cfg, e.data);
        end
      end
    end
    if (CFG_ACK) begin
      checks++;
      if (prev_cack) begin
        failures++;
        $display("FAIL cfg_ack_width at %0t: ack high for more than 1 cycle, required 1", $time);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL cfg_unexpected_ack at %0t: rdata=%02h, required no ack", $time, CFG_RDATA);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_cfg || (e.chk_data && CFG_RDATA != e.data)) begin
          failures++;
          $display("FAIL cfg_resp at %0t: got CFG rdata=%02h, required is_cfg=%0b data=%02h",
                   $time, CFG_RDATA, e.is_cfg, e.data);
        end
      end
    end
    prev_xack = XLAT_ACK;
    prev_cack = CFG_ACK;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLKX4);
      #1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge CLKX4);
    #1;
    pl_en   = 1'b0;
  endtask

  // Per-transaction observations, measured from the cycle REQ is raised
  int   lat, nrd_lo, nwr_lo, oe_hi;
  logic addr_ok, got;

  task automatic run_until_ack(input logic want_cfg, input logic [7:0] a);
    lat = 0; nrd_lo = 0; nwr_lo = 0; oe_hi = 0; addr_ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge CLKX4);
      #1;
      lat++;
      if (!MMU_nRD) begin nrd_lo++; if (MMU_ADDR != a) addr_ok = 1'b0; end
      if (!MMU_nWR) begin nwr_lo++; if (MMU_ADDR != a) addr_ok = 1'b0; end
      if (MMU_DATA_OE) oe_hi++;
      if (want_cfg ? CFG_ACK : XLAT_ACK) got = 1'b1;
    end
    chk("ack_seen", int'(got), 1);
  endtask

  task automatic do_xlat(input logic [7:0] a, input logic [7:0] d);
    XLAT_ADDR = a;
    XLAT_REQ  = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, d));
    run_until_ack(1'b0, a);
    XLAT_REQ  = 1'b0;
  endtask

  task automatic do_cfg(input logic rnw, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] d);
    CFG_RnW   = rnw;
    CFG_ADDR  = a;
    CFG_WDATA = wd;
    CFG_REQ   = 1'b1;
    exp_q.push_back(mk(1'b1, rnw, d));
    run_until_ack(1'b1, a);
    CFG_REQ   = 1'b0;
  endtask

  initial begin
    int   xa, xa_at_cfg, n;
    logic seen, done;
    logic [7:0] exp_56;
    RESET = 1'b1; XLAT_REQ = 1'b0; XLAT_ADDR = 8'h00;
    CFG_REQ = 1'b0; CFG_RnW = 1'b1; CFG_ADDR = 8'h00; CFG_WDATA = 8'h00;
    idle(3);

    // Reset values
    chk("rst_nrd", int'(MMU_nRD), 1);
    chk("rst_nwr", int'(MMU_nWR), 1);
    chk("rst_oe", int'(MMU_DATA_OE), 0);
    chk("rst_addr", int'(MMU_ADDR), 0);
    chk("rst_dout", int'(MMU_DATA_OUT), 0);
    chk("rst_xack", int'(XLAT_ACK), 0);
    chk("rst_cack", int'(CFG_ACK), 0);
    chk("rst_xdata", int'(XLAT_DATA), 0);
    chk("rst_rdata", int'(CFG_RDATA), 0);
`ifdef MMU_SEQ_INIT_EN
    chk("rst_init_busy", int'(INIT_BUSY), 1);
    // Identity fill: busy for 768 cycles; XLAT raised at cycle 10 waits
    RESET = 1'b0;
    begin
      int busy, fall, ack_n;
      busy = INIT_BUSY ? 1 : 0;
      fall = 0; ack_n = 0; got = 1'b0;
      XLAT_ADDR = 8'h12;
      exp_q.push_back(mk(1'b0, 1'b1, 8'h12));
      for (int i = 1; i <= 1200 && !got; i++) begin
        @(posedge CLKX4);
        #1;
        if (INIT_BUSY) busy++;
        else if (fall == 0) fall = i;
        if (i == 10) XLAT_REQ = 1'b1;
        if (XLAT_ACK) begin got = 1'b1; ack_n = i; XLAT_REQ = 1'b0; end
      end
      chk("init_busy_cycles", busy, 768);
      chk("init_xlat_seen", int'(got), 1);
      chk("init_xlat_after_busy", ack_n, fall + 3);
      n = 0;
      for (int i = 0; i < 256; i++) if (ram[i] != 8'(i)) n++;
      chk("init_identity_bad_entries", n, 0);
    end
    idle(1);
    exp_56 = 8'h56;
`else
    chk("rst_init_busy", int'(INIT_BUSY), 0);
    RESET = 1'b0;
    exp_56 = 8'hC3;
`endif
    preload(8'h12, 8'h5A);
    preload(8'h34, 8'h00);
    preload(8'h56, 8'hC3);
    idle(1);

    // Lookup at 0x12 returning 0x5A
    do_xlat(8'h12, 8'h5A);
    chk("x1_latency", lat, 3);
    chk("x1_nrd_cycles", nrd_lo, 2);
    chk("x1_addr", int'(addr_ok), 1);
    chk("x1_oe_cycles", oe_hi, 0);
    idle(2);
    chk("x1_data_hold", int'(XLAT_DATA), 8'h5A);

    // Config write 0x34 <- 0xA5, then read it back
    do_cfg(1'b0, 8'h34, 8'hA5, 8'h00);
    chk("w_latency", lat, 4);
    chk("w_oe_cycles", oe_hi, 3);
    chk("w_nwr_cycles", nwr_lo, 1);
    chk("w_nrd_cycles", nrd_lo, 0);
    chk("w_addr", int'(addr_ok), 1);
    chk("w_ram_value", int'(ram[8'h34]), 8'hA5);
    idle(1);
    do_cfg(1'b1, 8'h34, 8'h00, 8'hA5);
    chk("r_latency", lat, 3);
    chk("r_nrd_cycles", nrd_lo, 2);
    idle(1);

    // XLAT held while CFG pending: order XLAT, CFG, XLAT
    XLAT_ADDR = 8'h12; XLAT_REQ = 1'b1;
    CFG_RnW = 1'b1; CFG_ADDR = 8'h34; CFG_REQ = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 8'h5A));
    exp_q.push_back(mk(1'b1, 1'b1, 8'hA5));
    exp_q.push_back(mk(1'b0, 1'b1, 8'h5A));
    xa = 0; xa_at_cfg = -1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge CLKX4);
      #1;
      if (XLAT_ACK) xa++;
      if (CFG_ACK) begin CFG_REQ = 1'b0; xa_at_cfg = xa; end
      if (xa == 2) begin XLAT_REQ = 1'b0; done = 1'b1; end
    end
    XLAT_REQ = 1'b0; CFG_REQ = 1'b0;
    chk("arb_xlat_acks", xa, 2);
    chk("arb_xlat_before_cfg", xa_at_cfg, 1);
    idle(1);

    // Reset during the write strobe aborts with no ACK
    CFG_RnW = 1'b0; CFG_ADDR = 8'h78; CFG_WDATA = 8'h3C; CFG_REQ = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge CLKX4);
      #1;
      if (!MMU_nWR) seen = 1'b1;
    end
    chk("abort_strobe_seen", int'(seen), 1);
    RESET = 1'b1; CFG_REQ = 1'b0;
    @(posedge CLKX4);
    #1;
    chk("abort_nwr", int'(MMU_nWR), 1);
    chk("abort_oe", int'(MMU_DATA_OE), 0);
    chk("abort_cack", int'(CFG_ACK), 0);
    chk("abort_nrd", int'(MMU_nRD), 1);
    RESET = 1'b0;
`ifdef MMU_SEQ_INIT_EN
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge CLKX4);
      #1;
      if (!INIT_BUSY) seen = 1'b1;
    end
    chk("abort_reinit_done", int'(seen), 1);
`endif
    // Raised in the first cycle after reset: 3-cycle latency means IDLE
    do_xlat(8'h56, exp_56);
    chk("post_abort_latency", lat, 3);
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
